// File: rtl/cc_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cc_game_pkg
//  Brief   : Shared select codes, LFSR defaults and bus widths for the
//            pattern multiplexer and its control sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package cc_game_pkg;

   localparam int SELECTWIDTH = 2;
   localparam int RANDOMWIDTH = 4;

   localparam logic [SELECTWIDTH-1:0] SEL_COMIENZO = 2'd0;
   localparam logic [SELECTWIDTH-1:0] SEL_RANDOM   = 2'd1;
   localparam logic [SELECTWIDTH-1:0] SEL_TRANSI   = 2'd2;
   localparam logic [SELECTWIDTH-1:0] SEL_PIERDO   = 2'd3;

   // x^4 + x^3 + 1, Fibonacci form
   localparam logic [RANDOMWIDTH-1:0] LFSR_SEED = 4'b1001;
   localparam logic [RANDOMWIDTH-1:0] LFSR_TAPS = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/cc_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module  : cc_lfsr_gen
//  Brief   : Fibonacci LFSR with step/reload control and lock-up recovery.
//  Rev     : 1.0  initial release
// ============================================================================
module cc_lfsr_gen
   import cc_game_pkg::*;
#(
   parameter int                 WIDTH = RANDOMWIDTH,
   parameter logic [WIDTH-1:0]   SEED  = LFSR_SEED,
   parameter logic [WIDTH-1:0]   TAPS  = LFSR_TAPS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step,
   input  logic               reload,
   output logic [WIDTH-1:0]   value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic             feedback;

   always_comb begin
      feedback = ^(value_q & TAPS);
      value_d  = value_q;
      if (reload) begin
         value_d = SEED;
      end else if (step) begin
         // An all-zero register would never leave zero, so recover via SEED
         if (value_q == '0) begin
            value_d = SEED;
         end else begin
            value_d = {value_q[WIDTH-2:0], feedback};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= SEED;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/cc_mux4_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : cc_mux4_select_sequencer
//  Brief   : Game-phase FSM driving the 4-way pattern mux select, RANDOM
//            pattern source and pattern-register load strobe.
//            Optional feature macro: CC_SEQ_PAUSE_EN (adds CC_SEQ_pause_In).
//  Rev     : 1.0  initial release
// ============================================================================
module cc_mux4_select_sequencer
   import cc_game_pkg::*;
#(
   parameter int                            SEQ_SELECTWIDTH  = SELECTWIDTH,
   parameter int                            SEQ_RANDOMWIDTH  = RANDOMWIDTH,
   parameter int                            SEQ_LEVELWIDTH   = 3,
   parameter int                            SEQ_LEVEL_TICKS  = 16,
   parameter int                            SEQ_TRANSI_TICKS = 4,
   parameter logic [SEQ_RANDOMWIDTH-1:0]    SEQ_LFSR_SEED    = LFSR_SEED,
   parameter logic [SEQ_RANDOMWIDTH-1:0]    SEQ_LFSR_TAPS    = LFSR_TAPS
) (
   input  logic                          CC_SEQ_CLOCK_50,
   input  logic                          CC_SEQ_RESET_InLow,
   input  logic                          CC_SEQ_tick_In,
   input  logic                          CC_SEQ_start_In,
   input  logic                          CC_SEQ_lose_In,
`ifdef CC_SEQ_PAUSE_EN
   input  logic                          CC_SEQ_pause_In,
`endif
   output logic [SEQ_SELECTWIDTH-1:0]    CC_SEQ_select_Out,
   output logic [SEQ_RANDOMWIDTH-1:0]    CC_SEQ_random_Out,
   output logic                          CC_SEQ_load_Out,
   output logic [SEQ_LEVELWIDTH-1:0]     CC_SEQ_level_Out
);

   localparam logic [SEQ_SELECTWIDTH-1:0] ST_COMIENZO = SEQ_SELECTWIDTH'(SEL_COMIENZO);
   localparam logic [SEQ_SELECTWIDTH-1:0] ST_RANDOM   = SEQ_SELECTWIDTH'(SEL_RANDOM);
   localparam logic [SEQ_SELECTWIDTH-1:0] ST_TRANSI   = SEQ_SELECTWIDTH'(SEL_TRANSI);
   localparam logic [SEQ_SELECTWIDTH-1:0] ST_PIERDO   = SEQ_SELECTWIDTH'(SEL_PIERDO);

   localparam int CNT_MAX = (SEQ_LEVEL_TICKS > SEQ_TRANSI_TICKS) ? SEQ_LEVEL_TICKS
                                                                 : SEQ_TRANSI_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]          LEVEL_LAST  = CNT_W'(SEQ_LEVEL_TICKS - 1);
   localparam logic [CNT_W-1:0]          TRANSI_LAST = CNT_W'(SEQ_TRANSI_TICKS - 1);
   localparam logic [SEQ_LEVELWIDTH-1:0] LEVEL_MAX   = '1;

   logic                       clk;
   logic                       rst_n;
   logic                       tick_eff;
   logic                       start_edge;

   logic [SEQ_SELECTWIDTH-1:0] state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [SEQ_LEVELWIDTH-1:0]  level_q, level_d;
   logic                       start_q, start_d;
   logic                       load_q, load_d;
   logic                       lfsr_step;
   logic                       lfsr_reload;

   assign clk   = CC_SEQ_CLOCK_50;
   assign rst_n = CC_SEQ_RESET_InLow;

`ifdef CC_SEQ_PAUSE_EN
   // Pause only masks ticks; lose and start stay live so the game can still end/restart
   assign tick_eff = CC_SEQ_tick_In & ~CC_SEQ_pause_In;
`else
   assign tick_eff = CC_SEQ_tick_In;
`endif

   assign start_edge = CC_SEQ_start_In & ~start_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      start_d     = CC_SEQ_start_In;
      load_d      = tick_eff;
      lfsr_step   = 1'b0;
      lfsr_reload = 1'b0;

      case (state_q)
         ST_COMIENZO: begin
            if (start_edge) begin
               state_d = ST_RANDOM;
               cnt_d   = '0;
            end
         end
         ST_RANDOM: begin
            if (tick_eff) begin
               lfsr_step = 1'b1;
               if (cnt_q == LEVEL_LAST) begin
                  state_d = ST_TRANSI;
                  cnt_d   = '0;
                  if (level_q != LEVEL_MAX) begin
                     level_d = level_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // Losing overrides a coincident level-up
            if (CC_SEQ_lose_In) begin
               state_d = ST_PIERDO;
               cnt_d   = '0;
               level_d = level_q;
            end
         end
         ST_TRANSI: begin
            if (tick_eff) begin
               if (cnt_q == TRANSI_LAST) begin
                  state_d = ST_RANDOM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_PIERDO: begin
            if (start_edge) begin
               state_d     = ST_COMIENZO;
               level_d     = '0;
               lfsr_reload = 1'b1;
            end
         end
         default: begin
            state_d = ST_COMIENZO;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COMIENZO;
         cnt_q   <= '0;
         level_q <= '0;
         start_q <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         start_q <= start_d;
         load_q  <= load_d;
      end
   end

   cc_lfsr_gen #(
      .WIDTH  (SEQ_RANDOMWIDTH),
      .SEED   (SEQ_LFSR_SEED),
      .TAPS   (SEQ_LFSR_TAPS)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (lfsr_step),
      .reload (lfsr_reload),
      .value  (CC_SEQ_random_Out)
   );

   assign CC_SEQ_select_Out = state_q;
   assign CC_SEQ_load_Out   = load_q;
   assign CC_SEQ_level_Out  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_mux4_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cc_mux4_select_sequencer
//  Brief   : Scoreboard bench; every load strobe pops one expected
//            {select, random, level} record pushed when its tick was issued.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cc_mux4_select_sequencer;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] rnd;
      logic [2:0] lvl;
      bit         rnd_dc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       start;
   logic       lose;
`ifdef CC_SEQ_PAUSE_EN
   logic       pause;
`endif
   logic [1:0] sel_o;
   logic [3:0] rnd_o;
   logic       load_o;
   logic [2:0] lvl_o;

   exp_t       sb_q[$];
   int         n_tests;
   int         n_fail;
   int         idx;
   logic [3:0] lfsr_tab [15];

   cc_mux4_select_sequencer dut (
      .CC_SEQ_CLOCK_50    (clk),
      .CC_SEQ_RESET_InLow (rst_n),
      .CC_SEQ_tick_In     (tick),
      .CC_SEQ_start_In    (start),
      .CC_SEQ_lose_In     (lose),
`ifdef CC_SEQ_PAUSE_EN
      .CC_SEQ_pause_In    (pause),
`endif
      .CC_SEQ_select_Out  (sel_o),
      .CC_SEQ_random_Out  (rnd_o),
      .CC_SEQ_load_Out    (load_o),
      .CC_SEQ_level_Out   (lvl_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [3:0] r, input logic [2:0] l, input bit dc);
      exp_t e;
      e.sel = s; e.rnd = r; e.lvl = l; e.rnd_dc = dc;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise tick for one cycle; keep=1 leaves it high for a back-to-back tick
   task automatic do_tick(input bit keep);
      tick = 1'b1;
      cyc(1);
      if (!keep) tick = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
   endtask

   // Monitor: each load strobe is one pattern-register write to check
   always @(negedge clk) begin
      if (rst_n === 1'b1 && load_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_load: got load=1 expected no load at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("load_select", 32'(sel_o), 32'(e.sel));
            chk("load_level",  32'(lvl_o), 32'(e.lvl));
            if (!e.rnd_dc) chk("load_random", 32'(rnd_o), 32'(e.rnd));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lfsr_tab = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                   4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                   4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      n_tests = 0;
      n_fail  = 0;
      tick = 0; start = 0; lose = 0; rst_n = 1'b1;
`ifdef CC_SEQ_PAUSE_EN
      pause = 0;
`endif
      #3 rst_n = 1'b0;
      #1;
      chk("rst_select", 32'(sel_o),  32'd0);
      chk("rst_random", 32'(rnd_o),  32'h9);
      chk("rst_load",   32'(load_o), 32'd0);
      chk("rst_level",  32'(lvl_o),  32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Load strobe in COMIENZO
      push(2'd0, 4'b1001, 3'd0, 0);
      do_tick(0);
      cyc(2);

      // First level: gapped ticks, then back-to-back TRANSI ticks
      press_start();
      chk("start_to_random", 32'(sel_o), 32'd1);
      idx = 0;
      for (int k = 1; k <= 16; k++) begin
         idx = (idx + 1) % 15;
         push((k == 16) ? 2'd2 : 2'd1, lfsr_tab[idx], (k == 16) ? 3'd1 : 3'd0, 0);
         do_tick(0);
         cyc(1);
      end
      for (int t = 1; t <= 4; t++) begin
         push((t == 4) ? 2'd1 : 2'd2, lfsr_tab[idx], 3'd1, 0);
         do_tick(t < 4);
      end
      for (int k = 1; k <= 3; k++) begin
         idx = (idx + 1) % 15;
         push(2'd1, lfsr_tab[idx], 3'd1, 0);
         do_tick(k < 3);
      end
      cyc(2);

      // Reset mid-RANDOM with a tick pending: no load must follow
      tick = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_select", 32'(sel_o),  32'd0);
      chk("midrst_random", 32'(rnd_o),  32'h9);
      chk("midrst_load",   32'(load_o), 32'd0);
      chk("midrst_level",  32'(lvl_o),  32'd0);
      tick = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Lose coincident with the level-up tick; start edge in RANDOM ignored
      press_start();
      idx = 0;
      for (int k = 1; k <= 15; k++) begin
         idx = (idx + 1) % 15;
         push(2'd1, lfsr_tab[idx], 3'd0, 0);
         do_tick(k < 15);
      end
      start = 1'b1;
      cyc(1);
      chk("start_ignored_random", 32'(sel_o), 32'd1);
      lose = 1'b1;
      push(2'd3, 4'b0000, 3'd0, 1);
      do_tick(0);
      lose = 1'b0;
      cyc(1);
      push(2'd3, 4'b0000, 3'd0, 1);
      do_tick(0);
      cyc(2);
      chk("held_start_stays_pierdo", 32'(sel_o), 32'd3);
      start = 1'b0;
      cyc(1);
      press_start();
      chk("restart_select", 32'(sel_o), 32'd0);
      push(2'd0, 4'b1001, 3'd0, 0);
      do_tick(0);
      cyc(2);

      // Eight level-ups, continuous ticks: level saturates at 7
      press_start();
      idx = 0;
      for (int lv = 0; lv < 8; lv++) begin
         for (int k = 1; k <= 16; k++) begin
            idx = (idx + 1) % 15;
            push((k == 16) ? 2'd2 : 2'd1, lfsr_tab[idx],
                 (k == 16) ? ((lv < 7) ? 3'(lv + 1) : 3'd7) : 3'(lv), 0);
            do_tick(1);
         end
         for (int t = 1; t <= 4; t++) begin
            push((t == 4) ? 2'd1 : 2'd2, lfsr_tab[idx], (lv < 7) ? 3'(lv + 1) : 3'd7, 0);
            do_tick(!(lv == 7 && t == 4));
         end
      end
      cyc(2);
      chk("level_saturated", 32'(lvl_o), 32'd7);

`ifdef CC_SEQ_PAUSE_EN
      // Paused ticks neither load nor advance the LFSR/counter
      for (int k = 1; k <= 2; k++) begin
         idx = (idx + 1) % 15;
         push(2'd1, lfsr_tab[idx], 3'd7, 0);
         do_tick(0);
      end
      cyc(1);
      pause = 1'b1;
      for (int k = 1; k <= 5; k++) do_tick(0);
      cyc(1);
      chk("pause_random_held", 32'(rnd_o), 32'(lfsr_tab[idx]));
      pause = 1'b0;
      for (int k = 3; k <= 16; k++) begin
         idx = (idx + 1) % 15;
         push((k == 16) ? 2'd2 : 2'd1, lfsr_tab[idx], 3'd7, 0);
         do_tick(0);
      end
      for (int t = 1; t <= 4; t++) begin
         push((t == 4) ? 2'd1 : 2'd2, lfsr_tab[idx], 3'd7, 0);
         do_tick(0);
      end
      cyc(2);
      pause = 1'b1;
      lose  = 1'b1;
      cyc(1);
      lose  = 1'b0;
      chk("pause_lose_pierdo", 32'(sel_o), 32'd3);
      pause = 1'b0;
`endif

      tick = 1'b0;
      cyc(4);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
